// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle add/sub/negate/logic ops
// and an iterative unsigned shift-add multiply producing a 2*WIDTH-bit product.
module multicycle_alu #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 flag_n
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_NEGA = 3'b000;
  localparam logic [2:0] OP_NEGB = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t stateQ, stateNext;

  logic [2*WIDTH-1:0] mcandQ;
  logic [WIDTH-1:0]   mplierQ;
  logic [2*WIDTH-1:0] accQ;
  logic [CNT_W-1:0]   countQ;

  logic [WIDTH-1:0]   addX, addY;
  logic               addCin;
  logic [WIDTH:0]     addSum;
  logic               addV;
  logic [WIDTH-1:0]   aluRes;
  logic               aluC, aluV;
  logic [2*WIDTH-1:0] accNext;
  logic               accept, mulLast;

  assign accept  = in_valid && (stateQ == S_IDLE);
  assign mulLast = (countQ == CNT_W'(1));

  // Single adder path X + Y + cin shared by negate, add and subtract
  always_comb begin
    addX   = '0;
    addY   = '0;
    addCin = 1'b0;
    unique case (op)
      OP_NEGA: begin addY = ~a; addCin = 1'b1; end
      OP_NEGB: begin addY = ~b; addCin = 1'b1; end
      OP_ADD:  begin addX = a;  addY = b; end
      OP_SUB:  begin addX = a;  addY = ~b; addCin = 1'b1; end
      default: ;
    endcase
    addSum = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
    addV   = (addX[WIDTH-1] == addY[WIDTH-1]) && (addSum[WIDTH-1] != addX[WIDTH-1]);
  end

  always_comb begin
    aluRes = addSum[WIDTH-1:0];
    aluC   = addSum[WIDTH];
    aluV   = addV;
    unique case (op)
      OP_AND:  begin aluRes = a & b; aluC = 1'b0; aluV = 1'b0; end
      OP_OR:   begin aluRes = a | b; aluC = 1'b0; aluV = 1'b0; end
      OP_XOR:  begin aluRes = a ^ b; aluC = 1'b0; aluV = 1'b0; end
      default: ;
    endcase
  end

  // Multiplicand is pre-shifted each step, so it always carries the iteration weight
  assign accNext = accQ + (mplierQ[0] ? mcandQ : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      stateQ    <= stateNext;
      out_valid <= (stateNext == S_DONE);
    end
  end

  always_comb begin
    stateNext = stateQ;
    unique case (stateQ)
      S_IDLE:  if (in_valid) stateNext = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:   if (mulLast) stateNext = S_DONE;
      S_DONE:  if (out_ready) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (stateQ == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcandQ  <= '0;
      mplierQ <= '0;
      accQ    <= '0;
      countQ  <= '0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      flag_n  <= 1'b0;
    end else begin
      if (accept) begin
        if (op == OP_MUL) begin
          mcandQ  <= {{WIDTH{1'b0}}, a};
          mplierQ <= b;
          accQ    <= '0;
          countQ  <= CNT_W'(WIDTH);
        end else begin
          result  <= {{WIDTH{1'b0}}, aluRes};
          flag_z  <= (aluRes == '0);
          flag_c  <= aluC;
          flag_v  <= aluV;
          flag_n  <= aluRes[WIDTH-1];
        end
      end else if (stateQ == S_MUL) begin
        accQ    <= accNext;
        mcandQ  <= mcandQ << 1;
        mplierQ <= mplierQ >> 1;
        countQ  <= countQ - CNT_W'(1);
        if (mulLast) begin
          result <= accNext;
          flag_z <= (accNext == '0);
          flag_c <= (accNext[2*WIDTH-1:WIDTH] != '0);
          flag_v <= 1'b0;
          flag_n <= accNext[2*WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=4): directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_multicycle_alu;
  localparam int W = 4;
  localparam longint M = 64'd1 << W;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic z, c, v, n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [W-1:0] a, b;
  logic [2*W-1:0] result;
  logic flag_z, flag_c, flag_v, flag_n;

  int nCmp = 0;
  int nBad = 0;
  exp_t expQ[$];
  logic randDone;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sgn(input longint u);
    return (u >= M / 2) ? u - M : u;
  endfunction

  function automatic exp_t mk(input logic [2*W-1:0] r, input logic z, c, v, n);
    exp_t e;
    e.res = r; e.z = z; e.c = c; e.v = v; e.n = n;
    return e;
  endfunction

  // Reference: plain integer arithmetic on the operands' unsigned/signed values
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint ux, uy, r, s;
    logic c, v;
    exp_t e;
    ux = longint'(x); uy = longint'(y);
    c = 1'b0; v = 1'b0; r = 0; s = 0;
    case (o)
      3'b000: begin r = (M - ux) % M; c = (ux == 0); s = -sgn(ux); end
      3'b001: begin r = (M - uy) % M; c = (uy == 0); s = -sgn(uy); end
      3'b010: begin r = (ux + uy) % M; c = (ux + uy >= M); s = sgn(ux) + sgn(uy); end
      3'b011: begin r = (ux - uy + M) % M; c = (ux >= uy); s = sgn(ux) - sgn(uy); end
      3'b100: r = longint'(x & y);
      3'b101: r = longint'(x | y);
      3'b111: r = longint'(x ^ y);
      default: r = ux * uy;
    endcase
    if (o inside {3'b000, 3'b001, 3'b010, 3'b011})
      v = (s > M / 2 - 1) || (s < -(M / 2));
    e.res = r[2*W-1:0];
    e.z = (r == 0);
    e.c = (o == 3'b110) ? (r >= M) : c;
    e.v = v;
    e.n = (o == 3'b110) ? r[2*W-1] : r[W-1];
    return e;
  endfunction

  // Monitor: pops and compares on every retiring cycle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        chk("unexpected_output", 64'(result), 64'hDEAD);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("flag_z", 64'(flag_z), 64'(e.z));
        chk("flag_c", 64'(flag_c), 64'(e.c));
        chk("flag_v", 64'(flag_v), 64'(e.v));
        chk("flag_n", 64'(flag_n), 64'(e.n));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 64'(in_ready), 64'd1);
    end else begin
      op = o; a = x; b = y; in_valid = 1'b1;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] holdRes;
    logic [3:0] holdFlags;
    int edges;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    randDone = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({flag_z, flag_c, flag_v, flag_n}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD with single-cycle latency check
    issue(3'b010, 4'b1100, 4'b0001, mk(8'h0D, 0, 0, 0, 1));
    @(negedge clk);
    chk("add_latency_out_valid", 64'(out_valid), 64'd1);

    issue(3'b011, 4'b0011, 4'b0101, mk(8'h0E, 0, 0, 0, 1));
    issue(3'b000, 4'b1000, 4'b0000, mk(8'h08, 0, 0, 1, 1));
    issue(3'b001, 4'b0101, 4'b0000, mk(8'h00, 1, 1, 0, 0));
    issue(3'b100, 4'b1100, 4'b1010, mk(8'h08, 0, 0, 0, 1));
    issue(3'b101, 4'b1100, 4'b1010, mk(8'h0E, 0, 0, 0, 1));
    issue(3'b111, 4'b1100, 4'b1010, mk(8'h06, 0, 0, 0, 0));
    issue(3'b100, 4'b1100, 4'b0011, mk(8'h00, 1, 0, 0, 0));

    // MUL latency: out_valid appears after exactly WIDTH edges, in_ready low throughout
    issue(3'b110, 4'b1111, 4'b1111, mk(8'hE1, 0, 1, 0, 1));
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      chk("mul_in_ready_low", 64'(in_ready), 64'd0);
    end
    chk("mul_latency_edges", 64'(edges), 64'(W));

    // Backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    issue(3'b010, 4'b0110, 4'b0111, mk(8'h0D, 0, 0, 1, 1));
    @(negedge clk);
    holdRes = result;
    holdFlags = {flag_z, flag_c, flag_v, flag_n};
    chk("bp_value", 64'(holdRes), 64'h0D);
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_result_stable", 64'(result), 64'(holdRes));
      chk("bp_flags_stable", 64'({flag_z, flag_c, flag_v, flag_n}), 64'(holdFlags));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a multiply discards it
    issue(3'b110, 4'b0111, 4'b0011, mk(8'h15, 0, 0, 0, 0));
    @(posedge clk); #1 rst_n = 1'b0;
    expQ.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    chk("midmul_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midmul_rst_in_ready", 64'(in_ready), 64'd1);
    chk("midmul_rst_result", 64'(result), 64'd0);
    issue(3'b010, 4'b0111, 4'b0001, mk(8'h08, 0, 0, 1, 1));

    // Randomized ops with random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [2:0] ro;
          logic [W-1:0] ra, rb;
          ro = 3'($urandom); ra = W'($urandom); rb = W'($urandom);
          issue(ro, ra, rb, model(ro, ra, rb));
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1 out_ready = 1'b1;

    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
